// File: rtl/serial_adder_if.sv
// Handshake/data bundle for serial_adder.
//   start, a, b, cin : request side, driven by the requester (master)
//   busy, done       : status, driven by the adder (slave)
//   sum, cout        : registered result, driven by the adder (slave)
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell (two half adders + OR)
// is reused once per clock, LSB first, with a registered carry.
// Ports:
//   clk     : rising-edge clock
//   reset_p : asynchronous active-high reset
//   bus     : serial_adder_if slave (start/a/b/cin in; busy/done/sum/cout out)
// Latency: done pulses WIDTH cycles after the accepted start edge;
// minimum issue interval is WIDTH+2 cycles.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           reset_p,
    serial_adder_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("serial_adder: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Full-adder cell built from two half adders and an OR gate
    logic p;
    logic g1;
    logic s;
    logic g2;
    logic c_n;

    assign p   = a_sr[0] ^ b_sr[0];
    assign g1  = a_sr[0] & b_sr[0];
    assign s   = p ^ c;
    assign g2  = p & c;
    assign c_n = g1 | g2;

    // Partial-sum register with the current bit shifted into the MSB
    logic [WIDTH-1:0] s_next;
    assign s_next = {s, s_sr[WIDTH-1:1]};

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        c      <= bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_next;
                    c    <= c_n;
                    cnt  <= cnt + CNT_W'(1);
                    // Last bit: publish the complete result in one step
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum_q  <= s_next;
                        cout_q <= c_n;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vector table,
// multi-cycle corner sequences and random operations against a + b + cin.
module tb_serial_adder;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic reset_p;
    logic run_clk;

    int n_cmp;
    int n_fail;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus)
    );

    // Gated clock so reset can be exercised with the clock stopped low
    always begin
        #5;
        if (run_clk) clk = ~clk;
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Issue one operation from IDLE and wait for its done pulse.
    // Operand inputs are scrambled after capture; busy must stay high and the
    // old result must stay on sum until completion.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic icin, input string name,
                          output logic [WIDTH-1:0] os, output logic oc);
        int               lat;
        logic             busy_ok;
        logic             hold_ok;
        logic [WIDTH-1:0] prev_sum;
        prev_sum  = bus.sum;
        bus.a     = ia;
        bus.b     = ib;
        bus.cin   = icin;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = ~ia;
        bus.b     = ~ib;
        bus.cin   = ~icin;
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!bus.done && lat < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.sum !== prev_sum) hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(WIDTH));
        check({name, " busy during op"}, 32'(busy_ok), 32'd1);
        check({name, " sum held during op"}, 32'(hold_ok), 32'd1);
        check({name, " busy with done"}, 32'(bus.busy), 32'd0);
        os = bus.sum;
        oc = bus.cout;
        @(posedge clk); #1;
        check({name, " done one cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        vec_t             vecs[5];
        logic [WIDTH-1:0] rs;
        logic             rc;
        logic [WIDTH:0]   model;
        int               ndone;
        int               cyc;
        int               t_done[2];
        logic [WIDTH-1:0] s_done[2];
        logic             c_done[2];

        n_cmp     = 0;
        n_fail    = 0;
        clk       = 1'b0;
        run_clk   = 1'b0;
        reset_p   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h7F, cin: 1'b1, sum: 8'h00, cout: 1'b1};

        // Power-on reset with clock stopped
        #3 reset_p = 1'b1;
        #1;
        check("por busy", 32'(bus.busy), 32'd0);
        check("por done", 32'(bus.done), 32'd0);
        check("por sum", 32'(bus.sum), 32'd0);
        check("por cout", 32'(bus.cout), 32'd0);
        #3 reset_p = 1'b0;
        run_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, $sformatf("vec%0d", i), rs, rc);
            check($sformatf("vec%0d sum", i), 32'(rs), 32'(vecs[i].sum));
            check($sformatf("vec%0d cout", i), 32'(rc), 32'(vecs[i].cout));
        end

        // Asynchronous reset with clock stopped and a nonzero result held
        run_op(8'h5A, 8'h3C, 1'b0, "pre-reset", rs, rc);
        check("pre-reset sum", 32'(rs), 32'h96);
        @(negedge clk);
        run_clk = 1'b0;
        #12 reset_p = 1'b1;
        #1;
        check("async rst sum", 32'(bus.sum), 32'd0);
        check("async rst busy", 32'(bus.busy), 32'd0);
        check("async rst done", 32'(bus.done), 32'd0);
        #4 reset_p = 1'b0;
        run_clk = 1'b1;
        @(posedge clk); #1;

        // Start while busy is dropped
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        rs    = '0;
        rc    = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (bus.done) begin
                ndone++;
                rs = bus.sum;
                rc = bus.cout;
            end
            @(posedge clk); #1;
        end
        check("busy-prot done count", 32'(ndone), 32'd1);
        check("busy-prot sum", 32'(rs), 32'h46);
        check("busy-prot cout", 32'(rc), 32'd0);

        // Back-to-back with start held high
        bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 8'h01; bus.b = 8'h02;
        cyc   = 0;
        ndone = 0;
        while (ndone < 2 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done) begin
                t_done[ndone] = cyc;
                s_done[ndone] = bus.sum;
                c_done[ndone] = bus.cout;
                ndone++;
            end
        end
        bus.start = 1'b0;
        check("b2b done count", 32'(ndone), 32'd2);
        if (ndone == 2) begin
            check("b2b first latency", 32'(t_done[0]), 32'(WIDTH));
            check("b2b interval", 32'(t_done[1] - t_done[0]), 32'(WIDTH + 2));
            check("b2b res0", 32'({c_done[0], s_done[0]}), 32'h100);
            check("b2b res1", 32'({c_done[1], s_done[1]}), 32'h003);
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-operation aborts
        bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_p = 1'b1;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        reset_p = 1'b0;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus.done) ndone++;
            @(posedge clk); #1;
        end
        check("abort no done", 32'(ndone), 32'd0);
        check("abort sum", 32'(bus.sum), 32'd0);
        run_op(8'h0F, 8'h01, 1'b0, "post-abort", rs, rc);
        check("post-abort sum", 32'(rs), 32'h10);
        check("post-abort cout", 32'(rc), 32'd0);

        // Random operations against a + b + cin
        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rcin;
            ra    = WIDTH'($urandom);
            rb    = WIDTH'($urandom);
            rcin  = 1'($urandom);
            model = (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rcin);
            run_op(ra, rb, rcin, $sformatf("rnd%0d", n), rs, rc);
            check($sformatf("rnd%0d result %0h+%0h+%0d", n, ra, rb, rcin),
                  32'({rc, rs}), 32'(model));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
